// File: rtl/alu_operand_sel_pkg.sv
// Shared definitions for the ALU operand-selection stage: storage state
// encoding, out-of-range operand fill, and default geometry.
package alu_operand_sel_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_NUM_SRC = 4;

  // An out-of-range select yields an operand of all SELERR_FILL_BIT and raises SelErr.
  localparam logic SELERR_FILL_BIT = 1'b0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_operand_sel_alu_src_mux.sv
// NUM_SRC:1 operand selector with out-of-range flag.
// With ALU_OPSEL_FWD_EN defined, source 0 is replaced by a matching writeback.
import alu_operand_sel_pkg::*;

module alu_src_mux #(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
`ifdef ALU_OPSEL_FWD_EN
 ,parameter int unsigned RADDR_W = 5
`endif
) (
  input  logic [WIDTH-1:0]               reg_data_i,
  input  logic [(NUM_SRC-1)*WIDTH-1:0]   ext_data_i,
  input  logic [SEL_W-1:0]               sel_i,
`ifdef ALU_OPSEL_FWD_EN
  input  logic [RADDR_W-1:0]             rs_i,
  input  logic                           wb_valid_i,
  input  logic [RADDR_W-1:0]             wb_addr_i,
  input  logic [WIDTH-1:0]               wb_data_i,
`endif
  output logic [WIDTH-1:0]               operand_o,
  output logic                           sel_err_o
);

  logic [WIDTH-1:0] src0;
  logic             in_range;

`ifdef ALU_OPSEL_FWD_EN
  // Register 0 is never forwarded: it is the hard-wired zero register.
  assign src0 = (wb_valid_i && (wb_addr_i == rs_i) && (rs_i != '0)) ? wb_data_i : reg_data_i;
`else
  assign src0 = reg_data_i;
`endif

  always_comb begin
    operand_o = {WIDTH{SELERR_FILL_BIT}};
    in_range  = 1'b0;
    if (sel_i == '0) begin
      operand_o = src0;
      in_range  = 1'b1;
    end
    for (int unsigned k = 1; k < NUM_SRC; k++) begin
      if (sel_i == SEL_W'(k)) begin
        operand_o = ext_data_i[(k-1)*WIDTH +: WIDTH];
        in_range  = 1'b1;
      end
    end
  end

  assign sel_err_o = ~in_range;

endmodule

// File: rtl/alu_operand_sel.sv
// Registered operand-selection stage with a two-entry skid buffer.
// Optional writeback forwarding on source 0 via macro ALU_OPSEL_FWD_EN.
import alu_operand_sel_pkg::*;

module alu_operand_sel #(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC),
  parameter int unsigned RADDR_W = 5
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           InValid,
  output logic                           InReady,
  input  logic [WIDTH-1:0]               RegDataA,
  input  logic [WIDTH-1:0]               RegDataB,
  input  logic [(NUM_SRC-1)*WIDTH-1:0]   ExtData,
  input  logic [SEL_W-1:0]               SelA,
  input  logic [SEL_W-1:0]               SelB,
`ifdef ALU_OPSEL_FWD_EN
  input  logic [RADDR_W-1:0]             RsA,
  input  logic [RADDR_W-1:0]             RsB,
  input  logic                           WbValid,
  input  logic [RADDR_W-1:0]             WbAddr,
  input  logic [WIDTH-1:0]               WbData,
`endif
  output logic                           OutValid,
  input  logic                           OutReady,
  output logic [WIDTH-1:0]               OperandA,
  output logic [WIDTH-1:0]               OperandB,
  output logic                           SelErr
);

  if (NUM_SRC < 2 || RADDR_W < 1) begin : g_cfg_err
    $error("alu_operand_sel: NUM_SRC must be >= 2 and RADDR_W >= 1");
  end

  logic [WIDTH-1:0] a_d, b_d;
  logic             err_a, err_b, err_d;

  alu_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
`ifdef ALU_OPSEL_FWD_EN
   ,.RADDR_W (RADDR_W)
`endif
  ) u_mux_a (
    .reg_data_i (RegDataA),
    .ext_data_i (ExtData),
    .sel_i      (SelA),
`ifdef ALU_OPSEL_FWD_EN
    .rs_i       (RsA),
    .wb_valid_i (WbValid),
    .wb_addr_i  (WbAddr),
    .wb_data_i  (WbData),
`endif
    .operand_o  (a_d),
    .sel_err_o  (err_a)
  );

  alu_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
`ifdef ALU_OPSEL_FWD_EN
   ,.RADDR_W (RADDR_W)
`endif
  ) u_mux_b (
    .reg_data_i (RegDataB),
    .ext_data_i (ExtData),
    .sel_i      (SelB),
`ifdef ALU_OPSEL_FWD_EN
    .rs_i       (RsB),
    .wb_valid_i (WbValid),
    .wb_addr_i  (WbAddr),
    .wb_data_i  (WbData),
`endif
    .operand_o  (b_d),
    .sel_err_o  (err_b)
  );

  assign err_d = err_a | err_b;

  state_e           state_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;
  logic             main_err_q, skid_err_q;
  logic             accept;

  assign accept = InValid & in_ready_q;

  // Main register always drives the outputs; skid only fills when main is stalled.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_a_q    <= '0;
      main_b_q    <= '0;
      main_err_q  <= 1'b0;
      skid_a_q    <= '0;
      skid_b_q    <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_a_q    <= a_d;
            main_b_q    <= b_d;
            main_err_q  <= err_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !OutReady) begin
            skid_a_q   <= a_d;
            skid_b_q   <= b_d;
            skid_err_q <= err_d;
            in_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (accept && OutReady) begin
            main_a_q   <= a_d;
            main_b_q   <= b_d;
            main_err_q <= err_d;
          end else if (OutReady) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (OutReady) begin
            main_a_q   <= skid_a_q;
            main_b_q   <= skid_b_q;
            main_err_q <= skid_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign OperandA = main_a_q;
  assign OperandB = main_b_q;
  assign SelErr   = main_err_q;

endmodule
